// File: rtl/ras_ctrl.sv
// Return-address-stack front end: decodes retired calls/returns, queues stack ops, issues one per cycle, traps on CFI mismatch.
// Latency: an instruction accepted at edge N issues its first stack op in cycle N+1 at the earliest; mismatch is sampled the cycle after a RET.
// Backpressure: stall_o rises once the queue holds more than QDEPTH-2 entries (a two-entry coroutine always fits) and throughout FAULT.
module ras_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int QDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  valid_i,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] tgt_i,
  output logic                  stall_o,
  output logic                  push_o,
  output logic                  pop_o,
  output logic                  ret_o,
  output logic [DATA_WIDTH-1:0] din_o,
  input  logic                  stack_mismatch_i,
  input  logic                  stack_full_i,
  input  logic                  stack_empty_i,
  output logic                  trap_o,
  output logic [DATA_WIDTH-1:0] trap_addr_o,
  input  logic                  trap_ack_i,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic [15:0]           call_cnt_o,
  output logic [15:0]           ret_cnt_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_RET  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FAULT  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  // Queue storage and pointers
  op_e                   op_q  [QDEPTH];
  logic [DATA_WIDTH-1:0] dat_q [QDEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  // Control state
  state_e                state_q;
  logic                  trap_q;
  logic [DATA_WIDTH-1:0] trap_addr_q;
  logic [DATA_WIDTH-1:0] ret_dat_q;

  // Status
  logic                  overflow_q;
  logic                  underflow_q;
  logic [15:0]           call_cnt_q;
  logic [15:0]           ret_cnt_q;

  // Decode signals
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic                  rd_link;
  logic                  rs1_link;
  logic [DATA_WIDTH-1:0] link_addr;
  logic                  accept;

  logic [1:0]            enq_n;
  op_e                   enq0_op, enq1_op;
  logic [DATA_WIDTH-1:0] enq0_dat, enq1_dat;

  // Issue signals
  logic                  issue;
  op_e                   head_op;
  logic [DATA_WIDTH-1:0] head_dat;

  // The immediate field plays no part in the link-register convention.
  logic                  unused_imm;
  assign unused_imm = ^instr_i[31:20];

  assign opcode    = instr_i[6:0];
  assign rd        = instr_i[11:7];
  assign funct3    = instr_i[14:12];
  assign rs1       = instr_i[19:15];
  assign rd_link   = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link  = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign link_addr = pc_i + DATA_WIDTH'(4);

  // LOCKED releases the commit stage; FAULT holds it until the trap is taken.
  assign stall_o = (state_q == ST_FAULT) ||
                   ((state_q != ST_LOCKED) && (count_q > CW'(QDEPTH - 2)));

  assign accept = valid_i && !stall_o &&
                  ((state_q == ST_RUN) || (state_q == ST_CHECK));

  // Classify the retired instruction into zero, one or two queue entries
  always_comb begin
    enq_n    = 2'd0;
    enq0_op  = OP_NONE;
    enq0_dat = '0;
    enq1_op  = OP_NONE;
    enq1_dat = '0;
    if (accept) begin
      if (opcode == OPC_JAL) begin
        if (rd_link) begin
          enq_n    = 2'd1;
          enq0_op  = OP_PUSH;
          enq0_dat = link_addr;
        end
      end else if ((opcode == OPC_JALR) && (funct3 == 3'b000)) begin
        if (rd_link && !rs1_link) begin
          enq_n    = 2'd1;
          enq0_op  = OP_PUSH;
          enq0_dat = link_addr;
        end else if (!rd_link && rs1_link) begin
          enq_n    = 2'd1;
          enq0_op  = OP_RET;
          enq0_dat = tgt_i;
        end else if (rd_link && rs1_link && (rd != rs1)) begin
          // Coroutine swap: discard the old link, then save the new one.
          enq_n    = 2'd2;
          enq0_op  = OP_POP;
          enq0_dat = '0;
          enq1_op  = OP_PUSH;
          enq1_dat = link_addr;
        end else if (rd_link && rs1_link) begin
          enq_n    = 2'd1;
          enq0_op  = OP_PUSH;
          enq0_dat = link_addr;
        end
      end
    end
  end

  assign head_op  = op_q[rd_ptr_q];
  assign head_dat = dat_q[rd_ptr_q];
  assign issue    = (state_q == ST_RUN) && ena && (count_q != '0);

  // The head entry drives exactly one stack strobe while issuing
  always_comb begin
    push_o = 1'b0;
    pop_o  = 1'b0;
    ret_o  = 1'b0;
    din_o  = '0;
    if (issue) begin
      push_o = (head_op == OP_PUSH);
      pop_o  = (head_op == OP_POP);
      ret_o  = (head_op == OP_RET);
      din_o  = head_dat;
    end
  end

  // Next pointer/occupancy values; up to two writes and one read per cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(enq_n);
    rd_ptr_d = rd_ptr_q + PW'(issue);
    count_d  = count_q + CW'(enq_n) - CW'(issue);
  end

  // Queue pointers and occupancy; LOCKED discards everything still queued
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (state_q == ST_LOCKED) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue payload; only occupied slots are ever read, so no reset is needed
  always_ff @(posedge clk) begin
    if (enq_n != 2'd0) begin
      op_q[wr_ptr_q]  <= enq0_op;
      dat_q[wr_ptr_q] <= enq0_dat;
    end
    if (enq_n == 2'd2) begin
      op_q[wr_ptr_q + PW'(1)]  <= enq1_op;
      dat_q[wr_ptr_q + PW'(1)] <= enq1_dat;
    end
  end

  // Control FSM: RET compare window, trap raise, and permanent lock-out
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
      ret_dat_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // A RET against an empty stack has nothing to compare against.
          if (issue && (head_op == OP_RET) && !stack_empty_i) begin
            state_q   <= ST_CHECK;
            ret_dat_q <= head_dat;
          end
        end
        ST_CHECK: begin
          if (stack_mismatch_i) begin
            state_q     <= ST_FAULT;
            trap_q      <= 1'b1;
            trap_addr_q <= ret_dat_q;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_FAULT: begin
          if (trap_ack_i) begin
            state_q <= ST_LOCKED;
            trap_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_LOCKED;
          trap_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky over/underflow flags and saturating op counters, updated at issue
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      call_cnt_q  <= '0;
      ret_cnt_q   <= '0;
    end else begin
      if (push_o && stack_full_i) begin
        overflow_q <= 1'b1;
      end
      if ((pop_o || ret_o) && stack_empty_i) begin
        underflow_q <= 1'b1;
      end
      if (push_o && (call_cnt_q != 16'hFFFF)) begin
        call_cnt_q <= call_cnt_q + 16'd1;
      end
      if (ret_o && (ret_cnt_q != 16'hFFFF)) begin
        ret_cnt_q <= ret_cnt_q + 16'd1;
      end
    end
  end

  assign trap_o      = trap_q;
  assign trap_addr_o = trap_addr_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
  assign call_cnt_o  = call_cnt_q;
  assign ret_cnt_o   = ret_cnt_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: scoreboard of expected stack ops plus point checks.
// Inputs change 1 time unit after the rising edge; outputs are checked before inputs move.
// Issued ops are matched in order against the queue by a falling-edge monitor.
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [31:0] tgt_i;
  logic        stall_o;
  logic        push_o;
  logic        pop_o;
  logic        ret_o;
  logic [31:0] din_o;
  logic        stack_mismatch_i;
  logic        stack_full_i;
  logic        stack_empty_i;
  logic        trap_o;
  logic [31:0] trap_addr_o;
  logic        trap_ack_i;
  logic        overflow_o;
  logic        underflow_o;
  logic [15:0] call_cnt_o;
  logic [15:0] ret_cnt_o;

  always #5 clk = ~clk;

  ras_ctrl #(.DATA_WIDTH(32), .QDEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .ena              (ena),
    .valid_i          (valid_i),
    .instr_i          (instr_i),
    .pc_i             (pc_i),
    .tgt_i            (tgt_i),
    .stall_o          (stall_o),
    .push_o           (push_o),
    .pop_o            (pop_o),
    .ret_o            (ret_o),
    .din_o            (din_o),
    .stack_mismatch_i (stack_mismatch_i),
    .stack_full_i     (stack_full_i),
    .stack_empty_i    (stack_empty_i),
    .trap_o           (trap_o),
    .trap_addr_o      (trap_addr_o),
    .trap_ack_i       (trap_ack_i),
    .overflow_o       (overflow_o),
    .underflow_o      (underflow_o),
    .call_cnt_o       (call_cnt_o),
    .ret_cnt_o        (ret_cnt_o)
  );

  localparam logic [1:0]  E_PUSH = 2'd1;
  localparam logic [1:0]  E_POP  = 2'd2;
  localparam logic [1:0]  E_RET  = 2'd3;
  localparam logic [31:0] JAL_X1 = 32'h0000_00EF;  // jal  x1, 0
  localparam logic [31:0] JAL_X0 = 32'h0000_006F;  // jal  x0, 0
  localparam logic [31:0] RET_X1 = 32'h0000_8067;  // jalr x0, 0(x1)
  localparam logic [31:0] CORO   = 32'h0000_82E7;  // jalr x5, 0(x1)

  typedef struct {
    logic [1:0]  op;
    logic [31:0] dat;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(input logic [1:0] op, input logic [31:0] dat);
    exp_t e;
    e.op  = op;
    e.dat = dat;
    expq.push_back(e);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] tgt);
    valid_i = 1'b1;
    instr_i = ins;
    pc_i    = pc;
    tgt_i   = tgt;
  endtask

  // Every issued stack op must be the next one the bench expects
  always @(negedge clk) begin
    logic [1:0] got;
    exp_t       e;
    if (rst && (push_o || pop_o || ret_o)) begin
      got = ret_o ? E_RET : (pop_o ? E_POP : E_PUSH);
      chk("op_onehot", 32'(push_o) + 32'(pop_o) + 32'(ret_o), 32'd1);
      if (expq.size() == 0) begin
        chk("unexpected_op", {30'b0, got}, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("sb_op", {30'b0, got}, {30'b0, e.op});
        if (e.op != E_POP) chk("sb_din", din_o, e.dat);
      end
    end
  end

  initial begin
    rst = 1'b0; ena = 1'b0; valid_i = 1'b0; instr_i = '0; pc_i = '0; tgt_i = '0;
    stack_mismatch_i = 1'b0; stack_full_i = 1'b0; stack_empty_i = 1'b0; trap_ack_i = 1'b0;

    // Reset state
    cyc; cyc;
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_strobes", {29'b0, push_o, pop_o, ret_o}, 32'd0);
    chk("rst_trap", {31'b0, trap_o}, 32'd0);
    chk("rst_trap_addr", trap_addr_o, 32'd0);
    chk("rst_flags", {30'b0, overflow_o, underflow_o}, 32'd0);
    chk("rst_cnts", {call_cnt_o, ret_cnt_o}, 32'd0);
    rst = 1'b1;
    ena = 1'b1;

    // Call: JAL x1 at 0x100 pushes 0x104 the next cycle
    drive(JAL_X1, 32'h100, 32'h0); expect_op(E_PUSH, 32'h104);
    cyc; valid_i = 1'b0;
    chk("jal_push", {31'b0, push_o}, 32'd1);
    chk("jal_din", din_o, 32'h104);
    cyc;
    chk("jal_call_cnt", {16'b0, call_cnt_o}, 32'd1);
    chk("jal_idle", {31'b0, push_o}, 32'd0);

    // Non-link JAL enqueues nothing
    drive(JAL_X0, 32'h140, 32'h0);
    cyc; valid_i = 1'b0;
    chk("jal_x0_none", {29'b0, push_o, pop_o, ret_o}, 32'd0);

    // Return matching the stack; a call accepted during CHECK still issues afterwards
    drive(RET_X1, 32'h110, 32'h104); expect_op(E_RET, 32'h104);
    cyc; valid_i = 1'b0;
    chk("ret_issue", {31'b0, ret_o}, 32'd1);
    chk("ret_din", din_o, 32'h104);
    cyc;
    chk("check_no_issue", {29'b0, push_o, pop_o, ret_o}, 32'd0);
    drive(JAL_X1, 32'h180, 32'h0); expect_op(E_PUSH, 32'h184);
    cyc; valid_i = 1'b0;
    chk("post_check_push", {31'b0, push_o}, 32'd1);
    chk("ret_no_trap", {31'b0, trap_o}, 32'd0);
    chk("ret_cnt1", {16'b0, ret_cnt_o}, 32'd1);
    cyc;
    chk("call_cnt2", {16'b0, call_cnt_o}, 32'd2);

    // Coroutine swap: POP then PUSH(pc+4) on consecutive cycles
    drive(CORO, 32'h300, 32'h0);
    expect_op(E_POP, 32'h0); expect_op(E_PUSH, 32'h304);
    cyc; valid_i = 1'b0;
    chk("coro_pop", {31'b0, pop_o}, 32'd1);
    cyc;
    chk("coro_push", {31'b0, push_o}, 32'd1);
    chk("coro_din", din_o, 32'h304);
    cyc;
    chk("coro_idle", {29'b0, push_o, pop_o, ret_o}, 32'd0);

    // Fill with issue disabled: stall at three entries, fourth call ignored
    ena = 1'b0;
    drive(JAL_X1, 32'h400, 32'h0); expect_op(E_PUSH, 32'h404);
    cyc;
    chk("fill1_stall", {31'b0, stall_o}, 32'd0);
    drive(JAL_X1, 32'h404, 32'h0); expect_op(E_PUSH, 32'h408);
    cyc;
    chk("fill2_stall", {31'b0, stall_o}, 32'd0);
    drive(JAL_X1, 32'h408, 32'h0); expect_op(E_PUSH, 32'h40C);
    cyc;
    chk("fill3_stall", {31'b0, stall_o}, 32'd1);
    chk("fill_no_issue", {31'b0, push_o}, 32'd0);
    drive(JAL_X1, 32'h40C, 32'h0);
    cyc;
    chk("fill4_stall", {31'b0, stall_o}, 32'd1);
    valid_i = 1'b0;
    ena = 1'b1;
    #1;
    chk("drain1_din", din_o, 32'h404);
    cyc;
    chk("drain2_din", din_o, 32'h408);
    cyc;
    chk("drain3_din", din_o, 32'h40C);
    cyc;
    chk("drain_done", {30'b0, push_o, stall_o}, 32'd0);
    chk("call_cnt6", {16'b0, call_cnt_o}, 32'd6);

    // Push into a full stack still issues and sets sticky overflow
    stack_full_i = 1'b1;
    drive(JAL_X1, 32'h500, 32'h0); expect_op(E_PUSH, 32'h504);
    cyc; valid_i = 1'b0;
    chk("full_push", {31'b0, push_o}, 32'd1);
    cyc;
    stack_full_i = 1'b0;
    chk("overflow_set", {31'b0, overflow_o}, 32'd1);
    cyc;
    chk("overflow_sticky", {31'b0, overflow_o}, 32'd1);

    // RET on an empty stack: underflow, no CHECK, next op issues straight away
    stack_empty_i = 1'b1;
    drive(RET_X1, 32'h5F0, 32'h600); expect_op(E_RET, 32'h600);
    cyc;
    drive(JAL_X1, 32'h700, 32'h0); expect_op(E_PUSH, 32'h704);
    cyc; valid_i = 1'b0;
    chk("underflow_set", {31'b0, underflow_o}, 32'd1);
    chk("no_check_push", {31'b0, push_o}, 32'd1);
    cyc;
    stack_empty_i = 1'b0;
    chk("ret_cnt2", {16'b0, ret_cnt_o}, 32'd2);
    chk("call_cnt8", {16'b0, call_cnt_o}, 32'd8);

    // Mismatching return: trap held through FAULT, then ack locks the block
    drive(RET_X1, 32'h1F0, 32'h200); expect_op(E_RET, 32'h200);
    cyc; valid_i = 1'b0;
    stack_mismatch_i = 1'b1;
    cyc; cyc;
    for (int i = 0; i < 5; i++) begin
      chk("fault_trap", {31'b0, trap_o}, 32'd1);
      chk("fault_addr", trap_addr_o, 32'h200);
      chk("fault_stall", {31'b0, stall_o}, 32'd1);
      drive(JAL_X1, 32'h240, 32'h0);
      cyc;
    end
    valid_i = 1'b0;
    stack_mismatch_i = 1'b0;
    trap_ack_i = 1'b1;
    cyc;
    trap_ack_i = 1'b0;
    chk("locked_trap", {31'b0, trap_o}, 32'd0);
    chk("locked_stall", {31'b0, stall_o}, 32'd0);
    chk("ret_cnt3", {16'b0, ret_cnt_o}, 32'd3);
    drive(JAL_X1, 32'h800, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("locked_no_push", {31'b0, push_o}, 32'd0);
    end
    valid_i = 1'b0;

    // Leave LOCKED via reset, set overflow, reach FAULT, then reset mid-FAULT
    rst = 1'b0;
    cyc;
    rst = 1'b1;
    stack_full_i = 1'b1;
    drive(JAL_X1, 32'hA00, 32'h0); expect_op(E_PUSH, 32'hA04);
    cyc; valid_i = 1'b0;
    cyc;
    stack_full_i = 1'b0;
    drive(RET_X1, 32'hA10, 32'h900); expect_op(E_RET, 32'h900);
    cyc; valid_i = 1'b0;
    stack_mismatch_i = 1'b1;
    cyc; cyc;
    chk("fault2_trap", {31'b0, trap_o}, 32'd1);
    chk("fault2_overflow", {31'b0, overflow_o}, 32'd1);
    rst = 1'b0;
    cyc;
    rst = 1'b1;
    stack_mismatch_i = 1'b0;
    chk("rst2_trap", {31'b0, trap_o}, 32'd0);
    chk("rst2_trap_addr", trap_addr_o, 32'd0);
    chk("rst2_flags", {29'b0, overflow_o, underflow_o, stall_o}, 32'd0);
    chk("rst2_cnts", {call_cnt_o, ret_cnt_o}, 32'd0);
    drive(JAL_X1, 32'hB00, 32'h0); expect_op(E_PUSH, 32'hB04);
    cyc; valid_i = 1'b0;
    chk("rst2_run_push", {31'b0, push_o}, 32'd1);
    cyc; cyc;
    chk("sb_drained", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Front end of the return-address stack: decodes retired control-transfer instructions using the RISC-V link-register convention.
- Queues the resulting stack operations (push / pop / ret) and drives the stack one operation per cycle.
- Samples the stack's mismatch flag after each return and raises a control-flow-integrity trap to the core.
- Sits between the commit stage and the return-address stack.

Parameters:
DATA_WIDTH, 32, address/data width; must match the stack.
QDEPTH, 4, operation queue entries (power of two, >= 2).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
ena  in  1  issue enable; queue still accepts while low
valid_i  in  1  retired instruction valid
instr_i  in  32  retired instruction word
pc_i  in  DATA_WIDTH  PC of retired instruction
tgt_i  in  DATA_WIDTH  resolved jump target of retired instruction
stall_o  out  1  back-pressure to commit stage
push_o  out  1  stack push
pop_o  out  1  stack pop, no compare
ret_o  out  1  stack pop with compare against din_o
din_o  out  DATA_WIDTH  stack data / compare value
stack_mismatch_i  in  1  stack sticky mismatch flag
stack_full_i  in  1  stack full
stack_empty_i  in  1  stack empty
trap_o  out  1  CFI violation trap
trap_addr_o  out  DATA_WIDTH  offending return target
trap_ack_i  in  1  core acknowledges trap
overflow_o  out  1  sticky: push issued while stack full
underflow_o  out  1  sticky: pop/ret issued while stack empty
call_cnt_o  out  16  saturating count of issued pushes
ret_cnt_o  out  16  saturating count of issued rets

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0; queue empty; FSM = RUN; counters and sticky flags cleared. Reset overrides every state, including FAULT and LOCKED.
- Link register: rd or rs1 is x1 or x5.
- Decode (valid_i=1, stall_o=0, FSM in RUN or CHECK):
  - JAL (opcode 1101111), rd link: enqueue PUSH(pc_i+4).
  - JALR (opcode 1100111, funct3 000), by rd/rs1:
    - rd link, rs1 not link: PUSH(pc_i+4).
    - rd not link, rs1 link: RET(tgt_i).
    - both link, rd != rs1: POP then PUSH(pc_i+4), two entries enqueued in the same cycle.
    - both link, rd == rs1: PUSH(pc_i+4).
  - All other cases: nothing enqueued.
- Additions are modulo 2^DATA_WIDTH.
- valid_i while stall_o=1 is ignored. The commit stage must hold the instruction.
- stall_o = 1 when queue count > QDEPTH-2, so a two-entry coroutine always fits.
- Issue (FSM=RUN, ena=1, queue non-empty): head drives exactly one of push_o / pop_o / ret_o combinationally, with din_o = entry data. Head is dequeued at that edge.
- Latency: instruction accepted at edge N is issued in cycle N+1 at the earliest.
- Issue-time status:
  - PUSH with stack_full_i=1: still issued; overflow_o set.
  - POP or RET with stack_empty_i=1: still issued; underflow_o set; a RET then does not enter CHECK.
- Counters saturate at 0xFFFF. call_cnt_o counts every issued PUSH; ret_cnt_o every issued RET.
- FSM:
  - RUN: after issuing a RET with stack non-empty, go to CHECK.
  - CHECK: one cycle, no issue, enqueue still allowed. If stack_mismatch_i=1: FAULT, latch trap_addr_o = issued RET data. Else: RUN.
  - FAULT: trap_o=1, trap_addr_o held, no issue, stall_o=1. trap_ack_i=1 -> LOCKED.
  - LOCKED: trap_o=0; queue flushed; valid_i ignored; stall_o=0; no stack ops until reset.
- Simultaneous enqueue and dequeue in the same cycle: both occur; count is unchanged for single-entry enqueue.

Test Plan:
- JAL x1 at pc_i=0x100, ena=1 -> next cycle push_o=1, din_o=0x104; call_cnt_o=1.
- After the push, JALR x0,0(x1) with tgt_i=0x104 -> ret_o=1, din_o=0x104; CHECK with stack_mismatch_i=0 -> RUN, trap_o stays 0, ret_cnt_o=1.
- JALR x0,0(x1) with tgt_i=0x200, stack_mismatch_i=1 in CHECK -> trap_o=1, trap_addr_o=0x200, held 5 cycles; trap_ack_i pulse -> LOCKED, trap_o=0; a following JAL x1 produces no push_o.
- JALR x5,0(x1) at pc_i=0x300 -> pop_o=1 in one cycle, then push_o=1 with din_o=0x304 the next cycle.
- ena=0 with JAL x1 on three consecutive cycles -> stall_o=1 once count reaches 3 (QDEPTH=4), fourth valid_i ignored; ena=1 -> three pushes on consecutive cycles.
- stack_full_i=1 with JAL x1 -> push_o issued, overflow_o=1 sticky. rst=0 for one edge during FAULT -> all outputs 0, FSM=RUN.
